pause_fader: RTL and testbench
==============================

Name: pause_fader

Overview:
Parametrised successor pause controller for arcade cores.
- Merges N maskable pause sources, the user toggle button and the OSD-open pause.
- Optional single-frame step while user-paused.
- Replaces the one-shot halving dim with a timed, multi-level fade (progressive right-shift) and a registered RGB path.
- Sits between core video output and arcade_video; drives the CPU/core pause enable.

Parameters:
RW, 8, red channel width
GW, 8, green channel width
BW, 8, blue channel width
CLKSPD, 12, clk_sys frequency in MHz; 1 ms tick = CLKSPD*1000 cycles
NREQ, 2, number of external pause request inputs (>=1)
DIM_MS, 10000, ms of continuous pause before first dim step
FADE_MS, 500, ms between subsequent dim steps
MAX_SHIFT, 3, final dim level (right-shift amount), 1..7

Ports:
clk_sys  in  1  core system clock; the only clock
reset  in  1  asynchronous, active-high reset
user_button  in  1  pause toggle button, active-high, asynchronous to clk_sys
step_button  in  1  frame-step button, active-high; ignored unless PAUSE_FRAME_STEP_EN
pause_request  in  NREQ  external pause requests, active-high
req_mask  in  NREQ  per-source enable; bit i=1 enables pause_request[i]
options  in  2  [0] pause while OSD open; [1] dim enable
OSD_STATUS  in  1  OSD open, active-high
vblank  in  1  core vertical blank, clk_sys domain
r  in  RW  red
g  in  GW  green
b  in  BW  blue
pause_cpu  out  1  pause to core, active-high
dim_level  out  3  current fade level, 0..MAX_SHIFT
dim_video  out  1  dim_level != 0
rgb_out  out  RW+GW+BW  {r,g,b} after fade, registered

Behaviour:
- Reset (async assert, sync release):
  - state=RUN; button sync/edge flops 0; ms prescaler, ms counter, dim_level = 0; rgb_out=0.
  - pause_cpu forced 0 combinationally while reset high.
- Button inputs: user_button and step_button each pass a 2-flop synchroniser, then rising-edge detect (1-cycle pulse).
- State machine:
  - RUN: user edge -> PAUSED.
  - PAUSED: user edge -> RUN; step edge -> STEP (macro only).
  - STEP: vblank rising edge -> PAUSED; user edge -> RUN. User edge wins over vblank in the same cycle.
- pause_cpu = !reset & ( state==PAUSED | |(pause_request & req_mask) | (OSD_STATUS & options[0]) ). STEP does not assert pause_cpu by itself.
- A step requested while another source holds pause_cpu still completes on the next vblank rise with no effect on pause_cpu.
- Fade timing:
  - Timers run only while pause_cpu & options[1]; otherwise prescaler, ms counter and dim_level clear on the next edge. Any unpause, including STEP, restores full brightness.
  - Prescaler counts 0..CLKSPD*1000-1 and emits a tick on wrap.
  - ms counter saturates. dim_level becomes 1 when ms count reaches DIM_MS, then +1 every FADE_MS ticks, saturating at MAX_SHIFT.
  - All counters 32-bit; no wrap.
- Video: rgb_out <= {r>>dim_level, g>>dim_level, b>>dim_level}.
  - Latency 1 cycle; shifts are logical (zero-fill).
  - dim_level >= channel width yields 0 for that channel.
- dim_level and dim_video are registered outputs.

Optional Feature:
PAUSE_FRAME_STEP_EN
- Defined: STEP state and step_button behaviour as above.
- Undefined: STEP state absent and step_button unused; PAUSED leaves only on user edge or reset.

Decomposition:
- Package pause_pkg:
  - state enum {RUN, PAUSED, STEP}
  - option bit indices OPT_PAUSE_OSD=0, OPT_DIM=1
  - DIM_LVL_W=3
  - ms-tick constant function of CLKSPD
- Sub-module pause_dim_timer: prescaler, ms counter and dim_level fade; inputs run enable plus parameters.

Test Plan:
Sim parameters: CLKSPD=1, DIM_MS=4, FADE_MS=2, MAX_SHIFT=2, NREQ=2.
1. Reset release, then user_button pulse -> pause_cpu=1 within 4 cycles; second pulse -> pause_cpu=0. Assert reset while paused -> pause_cpu=0 immediately; state RUN after release.
2. pause_request=2'b10 with req_mask=2'b01 -> pause_cpu=0; req_mask=2'b11 -> pause_cpu=1. OSD_STATUS=1 with options=2'b00 -> 0; with options=2'b01 -> 1.
3. Paused with options[1]=1, r=0xF0 -> dim_level=1 and rgb_out red=0x78 at cycle 4000±2; dim_level=2 and red=0x3C at 6000±2; still 2 at 10000.
4. Dimmed at level 2, release pause -> dim_level=0 next cycle; rgb_out=full value one cycle later. options[1]=0 while paused -> no dimming.
5. (PAUSE_FRAME_STEP_EN) User-paused, step pulse -> pause_cpu=0 until the first vblank rise, then 1. Step pulse in RUN -> no effect. Step pulse and user pulse together -> RUN.
6. Step while pause_request[0]=1 (masked in) -> pause_cpu stays 1 throughout; state returns to PAUSED after the vblank rise.

Source files
------------

// File: rtl/pause_pkg.sv
// Shared types and constants for the pause_fader pause controller and its dim timer.
package pause_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        STEP   = 2'd2
    } pause_state_e;

    localparam int OPT_PAUSE_OSD = 0;
    localparam int OPT_DIM       = 1;
    localparam int DIM_LVL_W     = 3;

    // Number of clk_sys cycles in one millisecond for a clock of clkspd MHz.
    function automatic logic [31:0] ms_tick_cycles(input int clkspd);
        return 32'(clkspd) * 32'd1000;
    endfunction

endpackage

// File: rtl/pause_dim_timer.sv
// Millisecond prescaler, saturating pause-duration counter and multi-level fade stepper.
module pause_dim_timer
    import pause_pkg::*;
#(
    parameter int CLKSPD    = 12,
    parameter int DIM_MS    = 10000,
    parameter int FADE_MS   = 500,
    parameter int MAX_SHIFT = 3
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 run,
    output logic [DIM_LVL_W-1:0] dim_level,
    output logic                 dim_video
);

    localparam logic [31:0]          TICK_MAX   = ms_tick_cycles(CLKSPD) - 32'd1;
    localparam logic [31:0]          DIM_START  = 32'(DIM_MS);
    localparam logic [31:0]          FADE_STEP  = 32'(FADE_MS);
    localparam logic [DIM_LVL_W-1:0] LVL_MAX    = DIM_LVL_W'(MAX_SHIFT);

    logic [31:0]          presc_q, presc_d;
    logic [31:0]          ms_q, ms_d;
    logic [31:0]          fade_q, fade_d;
    logic [DIM_LVL_W-1:0] lvl_q, lvl_d;
    logic                 dim_video_q, dim_video_d;
    logic                 tick;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        fade_d  = fade_q;
        lvl_d   = lvl_q;
        tick    = 1'b0;
        if (!run) begin
            presc_d = '0;
            ms_d    = '0;
            fade_d  = '0;
            lvl_d   = '0;
        end else begin
            if (presc_q == TICK_MAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 32'd1;
            end
            if (tick) begin
                if (ms_q != '1) begin
                    ms_d = ms_q + 32'd1;
                end
                // First level is reached on elapsed time; later levels count FADE_MS ticks from the previous step.
                if (lvl_q == '0) begin
                    if (ms_d >= DIM_START) begin
                        lvl_d  = DIM_LVL_W'(1);
                        fade_d = '0;
                    end
                end else if (lvl_q < LVL_MAX) begin
                    if (fade_q + 32'd1 >= FADE_STEP) begin
                        lvl_d  = lvl_q + DIM_LVL_W'(1);
                        fade_d = '0;
                    end else begin
                        fade_d = fade_q + 32'd1;
                    end
                end
            end
        end
        dim_video_d = (lvl_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            ms_q        <= '0;
            fade_q      <= '0;
            lvl_q       <= '0;
            dim_video_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            ms_q        <= ms_d;
            fade_q      <= fade_d;
            lvl_q       <= lvl_d;
            dim_video_q <= dim_video_d;
        end
    end

    assign dim_level = lvl_q;
    assign dim_video = dim_video_q;

endmodule

// File: rtl/pause_fader.sv
// Pause controller with timed multi-level video fade; single-frame step is built
// only when PAUSE_FRAME_STEP_EN is defined.
module pause_fader
    import pause_pkg::*;
#(
    parameter int RW        = 8,
    parameter int GW        = 8,
    parameter int BW        = 8,
    parameter int CLKSPD    = 12,
    parameter int NREQ      = 2,
    parameter int DIM_MS    = 10000,
    parameter int FADE_MS   = 500,
    parameter int MAX_SHIFT = 3
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  user_button,
    input  logic                  step_button,
    input  logic [NREQ-1:0]       pause_request,
    input  logic [NREQ-1:0]       req_mask,
    input  logic [1:0]            options,
    input  logic                  OSD_STATUS,
    input  logic                  vblank,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic                  pause_cpu,
    output logic [DIM_LVL_W-1:0]  dim_level,
    output logic                  dim_video,
    output logic [RW+GW+BW-1:0]   rgb_out
);

    pause_state_e          state_q, state_d;
    logic [1:0]            user_sync_q, user_sync_d;
    logic                  user_prev_q;
    logic                  user_edge;
    logic [RW+GW+BW-1:0]   rgb_q, rgb_d;
    logic                  run;

    assign user_sync_d = {user_sync_q[0], user_button};
    assign user_edge   = user_sync_q[1] & ~user_prev_q;

`ifdef PAUSE_FRAME_STEP_EN
    logic [1:0] step_sync_q, step_sync_d;
    logic       step_prev_q;
    logic       step_edge;
    logic       vblank_prev_q;
    logic       vblank_rise;

    assign step_sync_d = {step_sync_q[0], step_button};
    assign step_edge   = step_sync_q[1] & ~step_prev_q;
    assign vblank_rise = vblank & ~vblank_prev_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            step_sync_q   <= '0;
            step_prev_q   <= 1'b0;
            vblank_prev_q <= 1'b0;
        end else begin
            step_sync_q   <= step_sync_d;
            step_prev_q   <= step_sync_q[1];
            vblank_prev_q <= vblank;
        end
    end
`else
    logic unused_step_inputs;
    assign unused_step_inputs = step_button | vblank;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:    if (user_edge) state_d = PAUSED;
            PAUSED: begin
                if (user_edge) begin
                    state_d = RUN;
`ifdef PAUSE_FRAME_STEP_EN
                end else if (step_edge) begin
                    state_d = STEP;
`endif
                end
            end
`ifdef PAUSE_FRAME_STEP_EN
            // User edge has priority over the vblank that would end the step.
            STEP: begin
                if (user_edge)        state_d = RUN;
                else if (vblank_rise) state_d = PAUSED;
            end
`endif
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            user_sync_q <= '0;
            user_prev_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            user_sync_q <= user_sync_d;
            user_prev_q <= user_sync_q[1];
            rgb_q       <= rgb_d;
        end
    end

    // Gated by reset so the core is released the instant reset asserts.
    assign pause_cpu = ~reset & ((state_q == PAUSED)
                                 | (|(pause_request & req_mask))
                                 | (OSD_STATUS & options[OPT_PAUSE_OSD]));

    assign run = pause_cpu & options[OPT_DIM];

    pause_dim_timer #(
        .CLKSPD   (CLKSPD),
        .DIM_MS   (DIM_MS),
        .FADE_MS  (FADE_MS),
        .MAX_SHIFT(MAX_SHIFT)
    ) u_dim_timer (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .run      (run),
        .dim_level(dim_level),
        .dim_video(dim_video)
    );

    assign rgb_d   = {r >> dim_level, g >> dim_level, b >> dim_level};
    assign rgb_out = rgb_q;

endmodule

// File: tb/tb_pause_fader.sv
// Directed self-checking bench for pause_fader with shortened fade timing.
module tb_pause_fader;

    localparam int NREQ = 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        user_button;
    logic        step_button;
    logic [1:0]  pause_request;
    logic [1:0]  req_mask;
    logic [1:0]  options;
    logic        OSD_STATUS;
    logic        vblank;
    logic [7:0]  r, g, b;
    logic        pause_cpu;
    logic [2:0]  dim_level;
    logic        dim_video;
    logic [23:0] rgb_out;

    int errors = 0;
    int checks = 0;

    pause_fader #(
        .RW(8), .GW(8), .BW(8), .CLKSPD(1), .NREQ(NREQ),
        .DIM_MS(4), .FADE_MS(2), .MAX_SHIFT(2)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .user_button  (user_button),
        .step_button  (step_button),
        .pause_request(pause_request),
        .req_mask     (req_mask),
        .options      (options),
        .OSD_STATUS   (OSD_STATUS),
        .vblank       (vblank),
        .r            (r),
        .g            (g),
        .b            (b),
        .pause_cpu    (pause_cpu),
        .dim_level    (dim_level),
        .dim_video    (dim_video),
        .rgb_out      (rgb_out)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0] req;
        logic [1:0] mask;
        logic [1:0] opt;
        logic       osd;
        logic [7:0] vr;
        logic [7:0] vg;
        logic [7:0] vb;
        logic       exp_pause;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic press(input logic u, input logic s);
        @(negedge clk_sys);
        user_button = u;
        step_button = s;
        cyc(2);
        user_button = 1'b0;
        step_button = 1'b0;
        cyc(4);
    endtask

    task automatic vblank_pulse();
        @(negedge clk_sys);
        vblank = 1'b1;
        cyc(2);
        vblank = 1'b0;
        cyc(1);
    endtask

    task automatic wait_pause(input logic target, output int n);
        n = 0;
        while (pause_cpu !== target && n < 10) begin
            @(negedge clk_sys);
            n++;
        end
    endtask

    task automatic wait_level(input logic [2:0] target, input int max_cyc, output int n);
        n = 0;
        while (dim_level !== target && n < max_cyc) begin
            @(negedge clk_sys);
            n++;
        end
    endtask

    initial begin
        int n, n2, total, low_cnt;

        vecs[0] = '{2'b00, 2'b11, 2'b00, 1'b0, 8'hF0, 8'h0F, 8'hA5, 1'b0};
        vecs[1] = '{2'b10, 2'b01, 2'b00, 1'b0, 8'h12, 8'h34, 8'h56, 1'b0};
        vecs[2] = '{2'b10, 2'b11, 2'b00, 1'b0, 8'hFF, 8'h00, 8'h80, 1'b1};
        vecs[3] = '{2'b01, 2'b01, 2'b00, 1'b0, 8'h01, 8'h02, 8'h03, 1'b1};
        vecs[4] = '{2'b01, 2'b10, 2'b00, 1'b0, 8'hAA, 8'h55, 8'hAA, 1'b0};
        vecs[5] = '{2'b00, 2'b11, 2'b00, 1'b1, 8'h7E, 8'h81, 8'h00, 1'b0};
        vecs[6] = '{2'b00, 2'b11, 2'b01, 1'b1, 8'hC3, 8'h3C, 8'h99, 1'b1};
        vecs[7] = '{2'b00, 2'b11, 2'b10, 1'b1, 8'h10, 8'h20, 8'h40, 1'b0};
        vecs[8] = '{2'b00, 2'b11, 2'b01, 1'b0, 8'hDE, 8'hAD, 8'hBE, 1'b0};
        vecs[9] = '{2'b11, 2'b00, 2'b11, 1'b1, 8'hEF, 8'hCA, 8'hFE, 1'b1};

        reset = 1'b1;
        user_button = 1'b0;
        step_button = 1'b0;
        pause_request = 2'b00;
        req_mask = 2'b11;
        options = 2'b00;
        OSD_STATUS = 1'b0;
        vblank = 1'b0;
        r = 8'h00; g = 8'h00; b = 8'h00;

        cyc(3);
        check("reset_pause", 32'(pause_cpu), 32'd0);
        check("reset_dim", 32'(dim_level), 32'd0);
        check("reset_rgb", 32'(rgb_out), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        cyc(2);

        // Toggle, then reset while paused.
        press(1'b1, 1'b0);
        check("user_pause", 32'(pause_cpu), 32'd1);
        press(1'b1, 1'b0);
        check("user_unpause", 32'(pause_cpu), 32'd0);
        press(1'b1, 1'b0);
        check("user_pause2", 32'(pause_cpu), 32'd1);
        #2 reset = 1'b1;
        #1 check("reset_while_paused", 32'(pause_cpu), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        cyc(4);
        check("run_after_reset", 32'(pause_cpu), 32'd0);

        // Source merge and undimmed video path.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_sys);
            pause_request = vecs[i].req;
            req_mask = vecs[i].mask;
            options = vecs[i].opt;
            OSD_STATUS = vecs[i].osd;
            r = vecs[i].vr; g = vecs[i].vg; b = vecs[i].vb;
            #1 check($sformatf("vec%0d_pause", i), 32'(pause_cpu), 32'(vecs[i].exp_pause));
            @(negedge clk_sys);
            check($sformatf("vec%0d_rgb", i), 32'(rgb_out), {8'h00, vecs[i].vr, vecs[i].vg, vecs[i].vb});
        end
        @(negedge clk_sys);
        pause_request = 2'b00;
        req_mask = 2'b11;
        options = 2'b00;
        OSD_STATUS = 1'b0;
        cyc(2);

        // Timed fade: level 1 at 4 ms, level 2 at 6 ms, saturated afterwards.
        options = 2'b10;
        r = 8'hF0; g = 8'h0F; b = 8'hFF;
        user_button = 1'b1;
        wait_pause(1'b1, n);
        check("fade_pause_seen", 32'(pause_cpu), 32'd1);
        user_button = 1'b0;
        wait_level(3'd1, 4100, n);
        check_range("dim1_time", n, 3998, 4002);
        check("dim1_level", 32'(dim_level), 32'd1);
        check("dim1_video", 32'(dim_video), 32'd1);
        @(negedge clk_sys);
        check("dim1_rgb", 32'(rgb_out), 32'h78077F);
        wait_level(3'd2, 2100, n2);
        total = n + 1 + n2;
        check_range("dim2_time", total, 5998, 6002);
        check("dim2_level", 32'(dim_level), 32'd2);
        @(negedge clk_sys);
        total++;
        check("dim2_rgb", 32'(rgb_out), 32'h3C033F);
        if (total < 10000) cyc(10000 - total);
        check("dim_saturated", 32'(dim_level), 32'd2);

        // Unpause restores brightness: level next cycle, video one cycle later.
        user_button = 1'b1;
        wait_pause(1'b0, n);
        check("unpause_seen", 32'(pause_cpu), 32'd0);
        user_button = 1'b0;
        @(negedge clk_sys);
        check("undim_level", 32'(dim_level), 32'd0);
        check("undim_video", 32'(dim_video), 32'd0);
        @(negedge clk_sys);
        check("undim_rgb", 32'(rgb_out), 32'hF00FFF);
        cyc(4);

        // Dim disabled while paused.
        options = 2'b00;
        press(1'b1, 1'b0);
        check("nodim_paused", 32'(pause_cpu), 32'd1);
        cyc(5000);
        check("nodim_level", 32'(dim_level), 32'd0);
        check("nodim_rgb", 32'(rgb_out), 32'hF00FFF);
        press(1'b1, 1'b0);
        check("nodim_unpause", 32'(pause_cpu), 32'd0);

`ifdef PAUSE_FRAME_STEP_EN
        // Single step from user pause.
        press(1'b1, 1'b0);
        check("step_paused", 32'(pause_cpu), 32'd1);
        press(1'b0, 1'b1);
        check("step_running", 32'(pause_cpu), 32'd0);
        cyc(5);
        check("step_still_running", 32'(pause_cpu), 32'd0);
        @(negedge clk_sys);
        vblank = 1'b1;
        #1 check("step_before_rise", 32'(pause_cpu), 32'd0);
        @(negedge clk_sys);
        check("step_after_rise", 32'(pause_cpu), 32'd1);
        vblank = 1'b0;
        cyc(2);

        // Step in RUN is ignored.
        press(1'b1, 1'b0);
        check("to_run", 32'(pause_cpu), 32'd0);
        press(1'b0, 1'b1);
        check("step_in_run", 32'(pause_cpu), 32'd0);
        vblank_pulse();
        check("step_in_run_vblank", 32'(pause_cpu), 32'd0);

        // Simultaneous step and user from PAUSED goes to RUN.
        press(1'b1, 1'b0);
        check("both_paused", 32'(pause_cpu), 32'd1);
        press(1'b1, 1'b1);
        check("both_run", 32'(pause_cpu), 32'd0);
        vblank_pulse();
        check("both_run_vblank", 32'(pause_cpu), 32'd0);

        // Step while another source holds pause.
        pause_request = 2'b01;
        req_mask = 2'b11;
        press(1'b1, 1'b0);
        check("held_paused", 32'(pause_cpu), 32'd1);
        low_cnt = 0;
        @(negedge clk_sys);
        step_button = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            if (i == 1) step_button = 1'b0;
            if (i == 5) vblank = 1'b1;
            if (pause_cpu !== 1'b1) low_cnt++;
        end
        vblank = 1'b0;
        check("held_low_cycles", 32'(low_cnt), 32'd0);
        pause_request = 2'b00;
        #1 check("held_back_paused", 32'(pause_cpu), 32'd1);
        press(1'b1, 1'b0);
        check("held_unpause", 32'(pause_cpu), 32'd0);
`else
        // Step button has no effect in this build.
        press(1'b1, 1'b0);
        check("nostep_paused", 32'(pause_cpu), 32'd1);
        press(1'b0, 1'b1);
        check("nostep_ignored", 32'(pause_cpu), 32'd1);
        vblank_pulse();
        check("nostep_vblank", 32'(pause_cpu), 32'd1);
        press(1'b1, 1'b0);
        check("nostep_unpause", 32'(pause_cpu), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
